// File: rtl/d5m_gen_pkg.sv
// Shared types and constants for the D5M frame generator.
// Build option: D5M_GEN_LFSR_EN enables the LFSR test pattern (mode 3).
package d5m_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FV_LEAD,
    ST_LINE_ACT,
    ST_LINE_BLK,
    ST_FV_TRAIL,
    ST_VBLANK
  } gen_state_t;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_FIXED = 2'd2,
    MODE_LFSR  = 2'd3
  } pattern_mode_t;

  localparam logic [2:0] RGB_R = 3'b100;
  localparam logic [2:0] RGB_G = 3'b010;
  localparam logic [2:0] RGB_B = 3'b001;

  // Index 0 (leftmost bar) is the last element: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting form: taps at bits 0, 2, 3, 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/d5m_pattern_pixel.sv
// Combinational pixel value for a Bayer (GR/BG) site under the latched mode.
// Build option: D5M_GEN_LFSR_EN adds the lfsr_bits input and mode 3 LFSR output.
module d5m_pattern_pixel
  import d5m_gen_pkg::*;
#(
  parameter int D5M_DATA_WIDTH = 12,
  parameter int H_ACTIVE       = 640,
  parameter int XW             = 10,
  parameter int YW             = 9
) (
  input  logic [XW-1:0]             x,
  input  logic [YW-1:0]             y,
  input  pattern_mode_t             mode,
  input  logic [D5M_DATA_WIDTH-1:0] fixed_value,
`ifdef D5M_GEN_LFSR_EN
  input  logic [D5M_DATA_WIDTH-1:0] lfsr_bits,
`endif
  output logic [D5M_DATA_WIDTH-1:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [D5M_DATA_WIDTH-1:0] ramp;
  logic [2:0]                bar_idx;
  logic [2:0]                bar_rgb;
  logic [2:0]                site_rgb;

  always_comb begin
    ramp    = D5M_DATA_WIDTH'(x) + D5M_DATA_WIDTH'(y);
    bar_idx = 3'(x / XW'(BAR_W));
    bar_rgb = BAR_RGB[bar_idx];
    // Even rows G,R,G,R...; odd rows B,G,B,G...
    if (!y[0]) site_rgb = x[0] ? RGB_R : RGB_G;
    else       site_rgb = x[0] ? RGB_G : RGB_B;

    pixel = ramp;
    case (mode)
      MODE_BARS:  pixel = (|(bar_rgb & site_rgb)) ? '1 : '0;
      MODE_FIXED: pixel = fixed_value;
`ifdef D5M_GEN_LFSR_EN
      MODE_LFSR:  pixel = lfsr_bits;
`endif
      default:    pixel = ramp;
    endcase
  end

endmodule

// File: rtl/d5m_frame_generator.sv
// D5M sensor-side transmitter: frame/line timing FSM with registered outputs.
// Build option: D5M_GEN_LFSR_EN enables the LFSR pattern for mode 3.
module d5m_frame_generator
  import d5m_gen_pkg::*;
#(
  parameter int D5M_DATA_WIDTH = 12,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int H_BLANK        = 16,
  parameter int FV_LEAD        = 4,
  parameter int FV_TRAIL       = 4,
  parameter int V_BLANK        = 32
) (
  input  logic                      pixclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [D5M_DATA_WIDTH-1:0] fixed_value,
  output logic                      ifval,
  output logic                      ilval,
  output logic [D5M_DATA_WIDTH-1:0] idata,
  output logic                      frame_done,
  output logic [15:0]               frame_count,
  output logic                      busy
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int CW = 16;

  gen_state_t                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [YW-1:0]             line_q, line_d;
  pattern_mode_t             mode_q, mode_d;
  logic [D5M_DATA_WIDTH-1:0] fixed_q, fixed_d;
  logic                      ifval_q, ifval_d;
  logic                      ilval_q, ilval_d;
  logic [D5M_DATA_WIDTH-1:0] idata_q, idata_d;
  logic                      frame_done_q, frame_done_d;
  logic [15:0]               frame_count_q, frame_count_d;
  logic                      busy_q, busy_d;
  logic                      fv_entry;
  logic [D5M_DATA_WIDTH-1:0] pixel;
`ifdef D5M_GEN_LFSR_EN
  logic [15:0]               lfsr_q, lfsr_d;
`endif

  // Pixel is evaluated at the next-cycle position so idata lands with ilval.
  d5m_pattern_pixel #(
    .D5M_DATA_WIDTH(D5M_DATA_WIDTH),
    .H_ACTIVE      (H_ACTIVE),
    .XW            (XW),
    .YW            (YW)
  ) u_pixel (
    .x          (XW'(cnt_d)),
    .y          (line_d),
    .mode       (mode_q),
    .fixed_value(fixed_q),
`ifdef D5M_GEN_LFSR_EN
    .lfsr_bits  (lfsr_q[D5M_DATA_WIDTH-1:0]),
`endif
    .pixel      (pixel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE:
        if (enable) begin
          state_d = ST_FV_LEAD;
          cnt_d   = '0;
        end
      ST_FV_LEAD:
        if (cnt_q == CW'(FV_LEAD - 1)) begin
          state_d = ST_LINE_ACT;
          cnt_d   = '0;
          line_d  = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_LINE_ACT:
        if (cnt_q == CW'(H_ACTIVE - 1)) begin
          state_d = ST_LINE_BLK;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_LINE_BLK:
        if (cnt_q == CW'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (line_q == YW'(V_ACTIVE - 1)) state_d = ST_FV_TRAIL;
          else begin
            state_d = ST_LINE_ACT;
            line_d  = line_q + 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      ST_FV_TRAIL:
        if (cnt_q == CW'(FV_TRAIL - 1)) begin
          state_d = ST_VBLANK;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      ST_VBLANK:
        if (cnt_q == CW'(V_BLANK - 1)) begin
          state_d = enable ? ST_FV_LEAD : ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    fv_entry = (state_d == ST_FV_LEAD) && (state_q != ST_FV_LEAD);
    mode_d   = fv_entry ? pattern_mode_t'(mode) : mode_q;
    fixed_d  = fv_entry ? fixed_value : fixed_q;
`ifdef D5M_GEN_LFSR_EN
    if (fv_entry)                     lfsr_d = LFSR_SEED;
    else if (state_d == ST_LINE_ACT)  lfsr_d = lfsr_next(lfsr_q);
    else                              lfsr_d = lfsr_q;
`endif

    ifval_d       = (state_d == ST_FV_LEAD) || (state_d == ST_LINE_ACT) ||
                    (state_d == ST_LINE_BLK) || (state_d == ST_FV_TRAIL);
    ilval_d       = (state_d == ST_LINE_ACT);
    idata_d       = ilval_d ? pixel : '0;
    busy_d        = (state_d != ST_IDLE);
    frame_done_d  = (state_d == ST_FV_TRAIL) && (cnt_d == CW'(FV_TRAIL - 1));
    frame_count_d = frame_count_q + 16'(frame_done_d);
  end

  always_ff @(posedge pixclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      line_q        <= '0;
      mode_q        <= MODE_RAMP;
      fixed_q       <= '0;
      ifval_q       <= 1'b0;
      ilval_q       <= 1'b0;
      idata_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
`ifdef D5M_GEN_LFSR_EN
      lfsr_q        <= LFSR_SEED;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      mode_q        <= mode_d;
      fixed_q       <= fixed_d;
      ifval_q       <= ifval_d;
      ilval_q       <= ilval_d;
      idata_q       <= idata_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
`ifdef D5M_GEN_LFSR_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign ifval       = ifval_q;
  assign ilval       = ilval_q;
  assign idata       = idata_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_d5m_frame_generator.sv
// Self-checking bench: per-frame expected waveform computed from frame timing
// arithmetic and pattern rules, compared cycle by cycle on the falling edge.
module tb_d5m_frame_generator;

  localparam int DW       = 12;
  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int H_BLANK  = 4;
  localparam int FV_LEAD  = 2;
  localparam int FV_TRAIL = 2;
  localparam int V_BLANK  = 6;
  localparam int LINE     = H_ACTIVE + H_BLANK;
  localparam int FRAME    = FV_LEAD + V_ACTIVE * LINE + FV_TRAIL;

  logic          pixclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] fixed_value;
  logic          ifval, ilval, frame_done, busy;
  logic [DW-1:0] idata;
  logic [15:0]   frame_count;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_count = 0;

  always #5 pixclk = ~pixclk;

  d5m_frame_generator #(
    .D5M_DATA_WIDTH(DW),
    .H_ACTIVE      (H_ACTIVE),
    .V_ACTIVE      (V_ACTIVE),
    .H_BLANK       (H_BLANK),
    .FV_LEAD       (FV_LEAD),
    .FV_TRAIL      (FV_TRAIL),
    .V_BLANK       (V_BLANK)
  ) dut (
    .pixclk     (pixclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .mode       (mode),
    .fixed_value(fixed_value),
    .ifval      (ifval),
    .ilval      (ilval),
    .idata      (idata),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_lfsr_step(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1;
    return (s >> 1) | (b << 15);
  endfunction

  function automatic logic [DW-1:0] model_pixel(input int m, input logic [DW-1:0] fv,
                                                input int x, input int y, input logic [15:0] s);
    int rgb [8];
    int site;
    rgb = '{7, 6, 3, 2, 5, 4, 1, 0};  // R=4 G=2 B=1 per bar, left to right
    if (y % 2 == 0) site = (x % 2 == 0) ? 2 : 4;
    else            site = (x % 2 == 0) ? 1 : 2;
    case (m)
      1: return ((rgb[x / (H_ACTIVE / 8)] & site) != 0) ? 12'hFFF : 12'h000;
      2: return fv;
`ifdef D5M_GEN_LFSR_EN
      3: return s[DW-1:0];
`endif
      default: return DW'(x + y);
    endcase
  endfunction

  // Entered at the falling edge of the first ifval cycle; returns at the
  // falling edge just after VBLANK.
  task automatic run_frame(input int m, input logic [DW-1:0] fv,
                           input int mid_k, input logic [1:0] mid_mode, input logic mid_en,
                           input logic [1:0] nxt_mode, input logic [DW-1:0] nxt_fixed);
    logic [15:0]   s;
    logic [DW-1:0] px;
    logic          il;
    int            rel;
    s = 16'hACE1;
    for (int k = 0; k < FRAME; k++) begin
      rel = k - FV_LEAD;
      il  = (rel >= 0) && (rel < V_ACTIVE * LINE) && ((rel % LINE) < H_ACTIVE);
      if (il) begin
        px = model_pixel(m, fv, rel % LINE, rel / LINE, s);
        s  = model_lfsr_step(s);
      end else px = '0;
      check($sformatf("ifval k=%0d", k), 32'(ifval), 32'd1);
      check($sformatf("ilval k=%0d", k), 32'(ilval), 32'(il));
      check($sformatf("idata k=%0d", k), 32'(idata), 32'(px));
      check($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(k == FRAME - 1));
      check($sformatf("frame_count k=%0d", k), 32'(frame_count),
            32'(16'((k == FRAME - 1) ? exp_count + 1 : exp_count)));
      check($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
      if (k == mid_k) begin
        mode   = mid_mode;
        enable = mid_en;
      end
      @(negedge pixclk);
    end
    exp_count++;
    mode        = nxt_mode;
    fixed_value = nxt_fixed;
    for (int k = 0; k < V_BLANK; k++) begin
      check($sformatf("vblank ifval k=%0d", k), 32'(ifval), 32'd0);
      check($sformatf("vblank ilval k=%0d", k), 32'(ilval), 32'd0);
      check($sformatf("vblank idata k=%0d", k), 32'(idata), 32'd0);
      check($sformatf("vblank busy k=%0d", k), 32'(busy), 32'd1);
      @(negedge pixclk);
    end
    $display("frame %0d mode %0d fixed %03h checked", exp_count, m, fv);
  endtask

  task automatic check_idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      check($sformatf("idle ifval k=%0d", k), 32'(ifval), 32'd0);
      check($sformatf("idle busy k=%0d", k), 32'(busy), 32'd0);
      @(negedge pixclk);
    end
  endtask

  initial begin
    int            cm, mm;
    logic [DW-1:0] cf;
    aresetn = 1'b0; enable = 1'b0; mode = 2'd0; fixed_value = '0;
    repeat (3) @(negedge pixclk);
    check("rst ifval", 32'(ifval), 32'd0);
    check("rst ilval", 32'(ilval), 32'd0);
    check("rst idata", 32'(idata), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst frame_count", 32'(frame_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    @(negedge pixclk);
    check_idle(3);

    enable = 1'b1; mode = 2'd0;
    @(negedge pixclk);
    run_frame(0, '0, -1, 2'd0, 1'b1, 2'd1, '0);
    run_frame(1, '0, -1, 2'd1, 1'b1, 2'd2, 12'h5A5);
    run_frame(2, 12'h5A5, FV_LEAD + 2 * LINE + 3, 2'd0, 1'b1, 2'd0, '0);
    run_frame(0, '0, -1, 2'd0, 1'b1, 2'd3, '0);
    run_frame(3, '0, -1, 2'd3, 1'b1, 2'd3, '0);
    cm = $urandom_range(0, 3);
    cf = DW'($urandom);
    run_frame(3, '0, -1, 2'd3, 1'b1, 2'(cm), cf);
    for (int i = 0; i < 4; i++) begin
      int            nm;
      logic [DW-1:0] nf;
      nm = $urandom_range(0, 3);
      nf = DW'($urandom);
      mm = $urandom_range(0, 3);
      run_frame(cm, cf, $urandom_range(0, FRAME - 1), 2'(mm), 1'b1, 2'(nm), nf);
      cm = nm;
      cf = nf;
    end

    // Enable dropped during line 1: frame and VBLANK still complete.
    run_frame(cm, cf, FV_LEAD + LINE + 2, 2'd0, 1'b0, 2'd0, '0);
    check_idle(10);

    enable = 1'b1; mode = 2'd0;
    @(negedge pixclk);
    check("pre-reset ifval", 32'(ifval), 32'd1);
    repeat (FV_LEAD + 3) @(negedge pixclk);
    check("pre-reset ilval", 32'(ilval), 32'd1);
    aresetn = 1'b0;
    @(negedge pixclk);
    aresetn = 1'b1;
    check("midrst ifval", 32'(ifval), 32'd0);
    check("midrst ilval", 32'(ilval), 32'd0);
    check("midrst idata", 32'(idata), 32'd0);
    check("midrst frame_done", 32'(frame_done), 32'd0);
    check("midrst frame_count", 32'(frame_count), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    exp_count = 0;
    @(negedge pixclk);
    run_frame(0, '0, 5, 2'd0, 1'b0, 2'd0, '0);
    check_idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
